dual_port_ram_pipe: RTL and testbench
=====================================

// Module: dual_port_ram_pipe
// PURPOSE
//  Parametrised single-clock simple dual-port RAM: one write port, one read port.
//  Successor to the 32x8 dual-port SRAM; adds per-byte write enables and a selectable
//  read latency (1 or 2). Also adds defined read-during-write collision behaviour and a
//  post-reset clear sweep. Sits under synchronous FIFOs and packet buffers that need
//  wider words and zeroed storage at start-up.
// PARAMETERS
//  DATA_W          32  data word width; must be a multiple of BYTE_W
//  BYTE_W          8   bits per write-enable lane; NBE = DATA_W/BYTE_W
//  ADDR_W          5   address width; DEPTH = 2**ADDR_W words
//  RD_LATENCY      1   rd_en to d_out/rd_valid latency in cycles; legal values 1 or 2
//  WR_FIRST        1   same-address collision: 1 = return new data, 0 = return old data
//  CLEAR_ON_RESET  1   1 = zero all words after reset release; 0 = no sweep
// PORTS
//  clk        in   1        single clock; all logic on posedge
//  rst_n      in   1        asynchronous, active-low reset
//  wr_en      in   1        write request
//  wr_addr    in   ADDR_W   write address
//  wr_be      in   NBE      byte-lane write enables; lane i covers d_in[i*BYTE_W +: BYTE_W]
//  d_in       in   DATA_W   write data
//  rd_en      in   1        read request
//  rd_addr    in   ADDR_W   read address
//  d_out      out  DATA_W   read data, registered
//  rd_valid   out  1        1-cycle pulse: d_out carries the result of a read
//  init_busy  out  1        clear sweep in progress; all requests are ignored
//  req_drop   out  1        1-cycle pulse: wr_en or rd_en arrived while init_busy=1
// BEHAVIOUR
//  - Reset (rst_n=0): d_out=0, rd_valid=0, req_drop=0.
//    Read pipeline flushed; FSM enters INIT if CLEAR_ON_RESET=1, else RUN.
//    init_busy=CLEAR_ON_RESET. Memory array is not reset by rst_n.
//  - FSM INIT: address counter runs 0..DEPTH-1, writing all-zero words, one per cycle.
//    INIT lasts DEPTH cycles after the first clk edge with rst_n=1.
//    After writing word DEPTH-1: go to RUN and drop init_busy on the same edge.
//    rst_n asserted mid-sweep: counter returns to 0 and the sweep restarts from word 0.
//  - FSM RUN: stays in RUN until reset.
//  - In INIT: wr_en/rd_en have no effect and no rd_valid is produced.
//    req_drop pulses on the cycle after any such request.
//  - Write (RUN): for each lane with wr_be[i]=1, mem[wr_addr] lane i <= d_in lane i.
//    Other lanes keep their contents. wr_en with wr_be=0 leaves memory unchanged.
//  - Read (RUN), RD_LATENCY=1: rd_en at edge N -> d_out=mem[rd_addr], rd_valid=1 after edge N.
//  - Read (RUN), RD_LATENCY=2: data and valid pass one extra register; result after edge N+1.
//  - Back-to-back reads every cycle give one result per cycle, in order, with no bubbles.
//  - d_out holds its last value while rd_valid=0; rd_valid deasserts the cycle after the last read.
//  - Collision (wr_en & rd_en & wr_addr==rd_addr, same edge):
//    WR_FIRST=1: per lane, returns d_in where wr_be=1 and old contents elsewhere.
//    WR_FIRST=0: returns the full pre-write word.
//  - Only the first read stage is forwarded. A write issued while a read is in the 2nd
//    stage (RD_LATENCY=2) does not alter that in-flight result.
//  - Addresses wrap naturally; every ADDR_W value is a legal address.
//  - Illegal RD_LATENCY, or DATA_W not a multiple of BYTE_W: elaboration-time error.
// TESTING
//  1. CLEAR_ON_RESET=1, ADDR_W=5: release rst_n.
//     -> init_busy=1 for 32 cycles; then reading addr 0..31 returns 0x00000000 each.
//  2. Write 0xDEADBEEF to addr 3 (wr_be=4'hF); then write 0x11223344 with wr_be=4'b0101.
//     -> read addr 3 returns 0xDE22BE44.
//  3. RD_LATENCY=2: rd_en on 4 consecutive cycles, addrs 0..3.
//     -> rd_valid high for 4 cycles starting 2 edges after the first rd_en; data in order.
//  4. Collision at addr 7 (old 0xAAAAAAAA, d_in 0x55555555, wr_be=4'b0011):
//     WR_FIRST=1 -> 0xAAAA5555; WR_FIRST=0 -> 0xAAAAAAAA.
//     Either way, a subsequent read returns 0xAAAA5555.
//  5. Pulse rst_n low at sweep word 10; also drive wr_en during INIT.
//     -> sweep restarts at 0 and lasts a full 32 cycles; req_drop pulses; memory all zero.
//  6. Reset with a read in flight (RD_LATENCY=2). -> no rd_valid pulse follows; d_out=0.

Source files
------------

// File: rtl/dual_port_ram_pipe.sv
// dual_port_ram_pipe: single-clock simple dual-port RAM (one write port, one read port)
// with per-byte write enables, selectable read latency (1 or 2), defined
// read-during-write collision behaviour and an optional post-reset zeroing sweep.
//
// Ports
//   clk        in   1        clock, all logic on posedge
//   rst_n      in   1        asynchronous active-low reset
//   wr_en      in   1        write request
//   wr_addr    in   ADDR_W   write address
//   wr_be      in   NBE      byte-lane write enables (lane i = d_in[i*BYTE_W +: BYTE_W])
//   d_in       in   DATA_W   write data
//   rd_en      in   1        read request
//   rd_addr    in   ADDR_W   read address
//   d_out      out  DATA_W   registered read data, holds while rd_valid=0
//   rd_valid   out  1        one-cycle pulse per completed read
//   init_busy  out  1        zeroing sweep in progress, requests ignored
//   req_drop   out  1        one-cycle pulse after a request ignored during the sweep
module dual_port_ram_pipe #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned BYTE_W         = 8,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned WR_FIRST       = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W/BYTE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0]          d_in,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          d_out,
    output logic                       rd_valid,
    output logic                       init_busy,
    output logic                       req_drop
);

    localparam int unsigned NBE   = DATA_W / BYTE_W;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Elaboration-time parameter legality.
    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("dual_port_ram_pipe: RD_LATENCY must be 1 or 2");
        end
        if (BYTE_W == 0 || (DATA_W % BYTE_W) != 0) begin : g_bad_width
            $error("dual_port_ram_pipe: DATA_W must be a non-zero multiple of BYTE_W");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   clr_addr_q;
    logic [ADDR_W-1:0]   clr_addr_d;
    logic                clr_we_c;
    logic                run_c;
    logic                wr_go_c;
    logic                rd_go_c;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_word_c;

    logic                s1_valid;
    logic [DATA_W-1:0]   s1_data;

    // State, sweep counter and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
            clr_addr_q <= '0;
            init_busy  <= (CLEAR_ON_RESET != 0);
            req_drop   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            init_busy  <= (state_d == ST_INIT);
            req_drop   <= !run_c && (wr_en || rd_en);
        end
    end

    // Next-state: sweep one word per cycle, leave INIT after the last word.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we_c   = 1'b0;
        run_c      = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                clr_we_c   = 1'b1;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                run_c = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign wr_go_c = wr_en && run_c;
    assign rd_go_c = rd_en && run_c;

    // Storage: sweep has priority; user writes are masked per byte lane.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_addr_q] <= '0;
        end else if (wr_go_c) begin
            for (int i = 0; i < int'(NBE); i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BYTE_W +: BYTE_W] <= d_in[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Read word with same-address forwarding of written lanes (write-first mode only).
    always_comb begin
        rd_word_c = mem[rd_addr];
        if (WR_FIRST != 0 && wr_go_c && (wr_addr == rd_addr)) begin
            for (int i = 0; i < int'(NBE); i++) begin
                if (wr_be[i]) begin
                    rd_word_c[i*BYTE_W +: BYTE_W] = d_in[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // First read stage; data only loads on a read so it holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_go_c;
            if (rd_go_c) begin
                s1_data <= rd_word_c;
            end
        end
    end

    // Optional second read stage; not forwarded, so later writes cannot disturb it.
    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                s2_valid;
            logic [DATA_W-1:0]   s2_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rd_valid = s2_valid;
            assign d_out    = s2_data;
        end else begin : g_lat1
            assign rd_valid = s1_valid;
            assign d_out    = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// Self-checking bench for dual_port_ram_pipe. Two instances share all inputs:
//   dut_a: RD_LATENCY=1, WR_FIRST=1
//   dut_b: RD_LATENCY=2, WR_FIRST=0
// A behavioural model (word array + per-read result history) predicts every output.
module tb_dual_port_ram_pipe;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NB    = 4;
    localparam int unsigned DEPTH = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [NB-1:0]   wr_be;
    logic [DW-1:0]   d_in;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;

    logic [DW-1:0]   d_out_a, d_out_b;
    logic            rd_valid_a, rd_valid_b;
    logic            init_busy_a, init_busy_b;
    logic            req_drop_a, req_drop_b;

    dual_port_ram_pipe #(
        .DATA_W(DW), .BYTE_W(8), .ADDR_W(AW),
        .RD_LATENCY(1), .WR_FIRST(1), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .d_in(d_in),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .d_out(d_out_a), .rd_valid(rd_valid_a),
        .init_busy(init_busy_a), .req_drop(req_drop_a)
    );

    dual_port_ram_pipe #(
        .DATA_W(DW), .BYTE_W(8), .ADDR_W(AW),
        .RD_LATENCY(2), .WR_FIRST(0), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .d_in(d_in),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .d_out(d_out_b), .rd_valid(rd_valid_b),
        .init_busy(init_busy_b), .req_drop(req_drop_b)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] mem_m [DEPTH];
    int            busy_cnt;
    logic          exp_v_a, exp_v_b, exp_drop, exp_busy;
    logic [DW-1:0] exp_d_a, exp_d_b;
    logic          pend_v;
    logic [DW-1:0] pend_d;

    function automatic logic [DW-1:0] be_mask(input logic [NB-1:0] be);
        logic [DW-1:0] m;
        m = '0;
        for (int l = 0; l < int'(NB); l++) begin
            if (be[l]) m = m | (DW'(32'hFF) << (8 * l));
        end
        return m;
    endfunction

    task automatic model_reset();
        busy_cnt = DEPTH;
        exp_v_a  = 1'b0; exp_d_a = '0;
        exp_v_b  = 1'b0; exp_d_b = '0;
        pend_v   = 1'b0; pend_d  = '0;
        exp_drop = 1'b0;
        exp_busy = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
    endtask

    // One rising edge with rst_n high, using the currently driven inputs.
    task automatic model_edge();
        logic          rv;
        logic [DW-1:0] old_w, new_w, m;
        rv = 1'b0; old_w = '0; new_w = '0;
        m  = be_mask(wr_be);
        if (busy_cnt > 0) begin
            exp_drop = wr_en || rd_en;
            busy_cnt--;
        end else begin
            exp_drop = 1'b0;
            if (rd_en) begin
                rv    = 1'b1;
                old_w = mem_m[rd_addr];
                new_w = (wr_en && wr_addr == rd_addr) ? ((d_in & m) | (old_w & ~m)) : old_w;
            end
            if (wr_en) mem_m[wr_addr] = (d_in & m) | (mem_m[wr_addr] & ~m);
        end
        // write-first, one cycle
        exp_v_a = rv;
        if (rv) exp_d_a = new_w;
        // read-first, two cycles: result of the previous edge emerges now
        exp_v_b = pend_v;
        if (pend_v) exp_d_b = pend_d;
        pend_v = rv;
        pend_d = old_w;
        exp_busy = (busy_cnt > 0);
    endtask

    task automatic check_outputs();
        check("a_valid", 32'(rd_valid_a), 32'(exp_v_a));
        check("a_dout",  d_out_a,         exp_d_a);
        check("b_valid", 32'(rd_valid_b), 32'(exp_v_b));
        check("b_dout",  d_out_b,         exp_d_b);
        check("a_busy",  32'(init_busy_a), 32'(exp_busy));
        check("b_busy",  32'(init_busy_b), 32'(exp_busy));
        check("a_drop",  32'(req_drop_a),  32'(exp_drop));
        check("b_drop",  32'(req_drop_b),  32'(exp_drop));
    endtask

    // Called at a negedge: drive, clock once, update model, check at next negedge.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [NB-1:0] be,
                        input logic [DW-1:0] di, input logic re, input logic [AW-1:0] ra);
        wr_en = we; wr_addr = wa; wr_be = be; d_in = di;
        rd_en = re; rd_addr = ra;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic rand_step(input int coll_pct);
        logic [AW-1:0] wa, ra;
        wa = AW'($urandom_range(0, DEPTH - 1));
        ra = ($urandom_range(0, 99) < coll_pct) ? wa : AW'($urandom_range(0, DEPTH - 1));
        step(1'($urandom_range(0, 1)), wa, NB'($urandom), $urandom,
             1'($urandom_range(0, 1)), ra);
    endtask

    // Assert reset at a negedge with random requests present; release at a later negedge.
    task automatic apply_reset(input int hold);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        for (int i = 0; i < hold; i++) begin
            wr_en = 1'($urandom_range(0, 1));
            rd_en = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            check_outputs();
        end
        rst_n = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; d_in = '0;
        rd_en = 1'b0; rd_addr = '0;
        model_reset();
        @(negedge clk);

        // Sweep interrupted at word 10 with writes issued during INIT, then full sweep.
        apply_reset(3);
        for (int i = 0; i < 10; i++) step(1'b1, AW'(i), 4'hF, 32'hFFFF_FFFF, 1'b0, '0);
        check("t5_busy_mid", 32'(init_busy_a), 32'd1);
        apply_reset(2);
        cnt = 0;
        do begin
            rand_step(20);
            cnt++;
        end while (init_busy_a && cnt < 40);
        check("t1_sweep_len", 32'(cnt), 32'd32);
        for (int i = 0; i < int'(DEPTH); i++) step(1'b0, '0, '0, '0, 1'b1, AW'(i));
        idle(3);

        // Byte-lane masked write.
        step(1'b1, 5'd3, 4'hF, 32'hDEAD_BEEF, 1'b0, '0);
        step(1'b1, 5'd3, 4'b0101, 32'h1122_3344, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 5'd3);
        check("t2_a_dout", d_out_a, 32'hDE22_BE44);
        idle(1);
        check("t2_b_dout", d_out_b, 32'hDE22_BE44);

        // Back-to-back reads, in order, no bubbles.
        for (int i = 0; i < 4; i++) step(1'b1, AW'(i), 4'hF, 32'hC0DE_0000 + 32'(i), 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, '0, 1'b1, AW'(i));
        idle(3);

        // Same-address collision.
        step(1'b1, 5'd7, 4'hF, 32'hAAAA_AAAA, 1'b0, '0);
        step(1'b1, 5'd7, 4'b0011, 32'h5555_5555, 1'b1, 5'd7);
        check("t4_a_coll", d_out_a, 32'hAAAA_5555);
        step(1'b0, '0, '0, '0, 1'b1, 5'd7);
        check("t4_b_coll", d_out_b, 32'hAAAA_AAAA);
        idle(1);
        check("t4_b_after", d_out_b, 32'hAAAA_5555);
        check("t4_a_after", d_out_a, 32'hAAAA_5555);

        // Randomized traffic with frequent collisions.
        for (int i = 0; i < 1500; i++) begin
            rand_step(30);
            if ($urandom_range(0, 19) == 0) idle(1);
        end
        idle(2);

        // Reset with a read in flight in the two-stage instance.
        step(1'b0, '0, '0, '0, 1'b1, 5'd7);
        apply_reset(1);
        idle(1);
        check("t6_b_valid", 32'(rd_valid_b), 32'd0);
        check("t6_b_dout",  d_out_b, 32'h0);
        idle(35);
        for (int i = 0; i < 40; i++) rand_step(25);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
